mem_rmw_seq: RTL and testbench
==============================

# mem_rmw_seq

Memory-access sequencer that sits directly downstream of the store-merge / load-extract stage in the multicycle MIPS datapath. It accepts one load or store request at a time from the control unit and drives the single-port data memory. Word stores are written directly. Half-word and byte stores use a read-modify-write: the block fetches the old word, the merge stage combines it with the store data, and the block writes the merged word back. For loads it captures the memory word, routes it through the extract stage and returns the result.

## Interface
Parameters:
- MEM_LAT, 1: cycles from the mem_rd strobe to valid mem_rdata; legal range 1..7.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  2  access size: 00 word, 01 half, 10 byte; 11 is treated as word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data from the register file.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  write data; equals wm_memout.
- mem_rdata  in  32  memory read data.
- wm_regin  out  32  registered store data, to the merge stage RegIn.
- wm_memin  out  32  captured memory word, to the merge stage MemIn.
- wm_mode  out  2  registered mode, to the merge stage mode.
- wm_memout  in  32  merged word from the merge stage.
- wm_regout  in  32  extracted load value from the merge stage.
- load_data  out  32  load result; holds until the next load completes.
- done  out  1  one-cycle completion pulse.
- align_err  out  1  pulses with done on a misaligned request.

## Operation
- Handshake: a request is accepted when req_valid and req_ready are both 1. req_ready is 1 only in IDLE. On acceptance, addr, mode, write flag and wdata are latched.
- Misalignment rule:
  - Word access with addr[1:0] != 0 is misaligned.
  - Half access with addr[0] != 0 is misaligned.
  - A misaligned request goes IDLE -> DONE with align_err=1. No mem_rd or mem_wr is issued, and load_data is unchanged.
- States: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE -> WRITE: aligned word store.
  - IDLE -> READ: load, or half/byte store.
  - READ lasts one cycle with mem_rd=1, then goes to WAIT.
  - WAIT lasts MEM_LAT cycles, counted down by the latency counter. On the last WAIT cycle, mem_rdata is sampled into the capture register (wm_memin).
  - WAIT -> DONE for a load; load_data is registered from wm_regout at the DONE transition.
  - WAIT -> WRITE for a half/byte store.
  - WRITE lasts one cycle with mem_wr=1, then goes to DONE.
  - DONE lasts one cycle with done=1, then returns to IDLE.
- mem_addr is the latched word address and is valid in READ, WAIT and WRITE.
- Mode 11 follows the word path exactly.
- Reset values: req_ready=1; mem_rd=0; mem_wr=0; done=0; align_err=0; load_data=0; wm_memin=0; wm_regin=0; wm_mode=0; state=IDLE.

## Timing
Request accepted in cycle T:
- Word store: mem_wr in T+1; done in T+2.
- Load: mem_rd in T+1; mem_rdata sampled in T+1+MEM_LAT; done in T+2+MEM_LAT; load_data valid from T+2+MEM_LAT.
- Half/byte store: as a load until capture; mem_wr in T+2+MEM_LAT; done in T+3+MEM_LAT.
- Misaligned request: done and align_err in T+1.

Boundary conditions:
- req_valid asserted while busy is ignored (not latched). The next request can be accepted in the cycle after done.
- Reset mid-operation: mem_rd and mem_wr drop immediately (asynchronous reset), the FSM returns to IDLE, and the pending access is abandoned with no done pulse.
- The latency counter reloads on every entry to WAIT. There is no wrap-around beyond MEM_LAT.

## Structure
- Shared package mem_pkg:
  - mode_t enum: MODE_WORD=2'b00, MODE_HALF=2'b01, MODE_BYTE=2'b10.
  - state_t enum for the FSM.
  - MEM_LAT_MAX=7.
- The merge/extract stage stays external and is connected through the wm_* ports.
- One natural sub-module: mem_lat_counter, a 3-bit loadable down-counter with a zero flag, driving the WAIT exit.

## Test plan
- Word store, addr 0x0000_0010, wdata 0xDEADBEEF, MEM_LAT=1 -> mem_wr in T+1 at 0x10 with mem_wdata=0xDEADBEEF; no mem_rd; done in T+2.
- Byte store, addr 0x0000_0020, wdata 0x0000_00AB, memory holds 0x11223344, MEM_LAT=2 -> mem_rd in T+1; mem_wr in T+4 with 0x112233AB; done in T+5.
- Half load, addr 0x0000_0008, memory holds 0xCAFEBABE, MEM_LAT=3 -> done in T+5 with load_data=0x0000BABE; no mem_wr.
- Misaligned half store, addr 0x0000_0003 -> done and align_err in T+1; no memory strobes; load_data unchanged.
- reset_n pulsed low during WAIT of a byte store -> mem_rd and mem_wr stay 0, no done pulse, req_ready=1 after release; a following word load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Latency: none (types and pure functions only).
// Backpressure: none.
package mem_pkg;

    localparam int MEM_LAT_MAX = 7;

    typedef enum logic [1:0] {
        MODE_WORD = 2'b00,
        MODE_HALF = 2'b01,
        MODE_BYTE = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The reserved encoding 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == MODE_HALF || mode == MODE_BYTE) ? mode : MODE_WORD;
    endfunction

    function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (mode)
            MODE_HALF: bad = off[0];
            MODE_BYTE: bad = 1'b0;
            default:   bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable 3-bit down-counter timing the memory read latency.
// Latency: load/decrement take effect on the next rising edge; zero is combinational.
// Backpressure: none; holds at zero until reloaded.
module mem_lat_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] load_val,
    output logic       zero
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/mem_rmw_seq.sv
// Load/store sequencer for a single-port data memory with read-modify-write for sub-word stores.
// Latency: word store 2, load 2+MEM_LAT, sub-word store 3+MEM_LAT, misaligned 1 cycle to done.
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored.
module mem_rmw_seq #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wm_regin,
    output logic [31:0] wm_memin,
    output logic [1:0]  wm_mode,
    input  logic [31:0] wm_memout,
    input  logic [31:0] wm_regout,
    output logic [31:0] load_data,
    output logic        done,
    output logic        align_err
);
    import mem_pkg::*;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [29:0] addr_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] memin_q;
    logic [1:0]  mode_in;
    logic        bad_in;
    logic        accept;
    logic        lat_zero;
    logic        capture;

    assign mode_in = norm_mode(req_mode);
    assign bad_in  = misaligned(mode_in, req_addr[1:0]);
    assign accept  = (state == S_IDLE) && req_valid;
    assign capture = (state == S_WAIT) && lat_zero;

    mem_lat_counter u_lat (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state == S_READ),
        .dec      ((state == S_WAIT) && !lat_zero),
        .load_val (LAT_LOAD),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad_in) begin
                        state_nxt = S_DONE;
                    end else if (req_write && mode_in == MODE_WORD) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_rd    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (lat_zero) begin
                    state_nxt = write_q ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                mem_wr    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wm_regin  <= '0;
            wm_mode   <= MODE_WORD;
            memin_q   <= '0;
            load_data <= '0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr[31:2];
                write_q  <= req_write;
                err_q    <= bad_in;
                wm_regin <= req_wdata;
                wm_mode  <= mode_in;
            end
            if (capture) begin
                memin_q <= mem_rdata;
                if (!write_q) begin
                    load_data <= wm_regout;
                end
            end
        end
    end

    // On the capture cycle the merge stage sees the live read data, so the
    // extracted load value can be registered on the same edge as the capture.
    assign wm_memin  = capture ? mem_rdata : memin_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wm_memout;
    assign align_err = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_rmw_seq.sv
module tb_mem_rmw_seq;
    localparam int L = 3;

    logic        clk, reset_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] wm_regin, wm_memin, wm_memout, wm_regout, load_data;
    logic [1:0]  wm_mode;
    logic        done, align_err;

    mem_rmw_seq #(.MEM_LAT(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wm_regin(wm_regin), .wm_memin(wm_memin), .wm_mode(wm_mode),
        .wm_memout(wm_memout), .wm_regout(wm_regout),
        .load_data(load_data), .done(done), .align_err(align_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] mode, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (mode)
            2'b01: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            2'b10: r[int'(off)*8 +: 8] = d[7:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] mode,
                                            input logic [1:0] off);
        logic [31:0] r;
        r = w;
        case (mode)
            2'b01: r = off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
            2'b10: r = {24'h0, w[int'(off)*8 +: 8]};
            default: r = w;
        endcase
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with exact read latency: data is only valid L cycles after the strobe.
    logic [31:0] bmem [0:63];
    logic [L-1:0] rd_pipe;
    logic preload;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= '0;
        else          rd_pipe <= {rd_pipe[L-2:0], mem_rd};
    end
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) bmem[i] <= 32'h0;
            bmem[2] <= 32'hCAFEBABE;
            bmem[8] <= 32'h11223344;
            bmem[9] <= 32'h99887766;
        end else if (mem_wr) begin
            bmem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    always @* mem_rdata = rd_pipe[L-1] ? bmem[mem_addr[7:2]] : 32'hBAD0BAD0;

    // External merge/extract stage; lane offset comes from the accepted address.
    logic [1:0] cur_off;
    always @* begin
        wm_memout = merge_word(wm_memin, wm_regin, wm_mode, cur_off);
        wm_regout = extract(wm_memin, wm_mode, cur_off);
    end

    // Reference model: per-request schedule derived from the timing rules.
    logic [31:0] ref_mem [0:63];
    int e_busy = -1, e_rd = -1, e_wr = -1, e_done = -1;
    bit e_err = 0, e_isload = 0, e_sub = 0, e_mode_chk = 0;
    logic [31:0] e_wdata = 0, e_addrw = 0, e_old = 0, e_load = 0, e_regin = 0, exp_load = 0;
    logic [1:0]  e_mode = 0;
    int last_t0 = 0, last_done = -100;
    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit busy;
            busy = (cyc >= e_busy) && (cyc <= e_done);
            if (cyc == e_done && e_isload) exp_load = e_load;
            if (done) last_done = cyc;
            chk("req_ready", req_ready, !busy);
            chk("mem_rd", mem_rd, cyc == e_rd);
            chk("mem_wr", mem_wr, cyc == e_wr);
            chk("done", done, cyc == e_done);
            chk("align_err", align_err, (cyc == e_done) && e_err);
            chk("load_data", load_data, exp_load);
            if (cyc == e_rd) chk("rd_addr", mem_addr, e_addrw);
            if (cyc == e_wr) begin
                chk("wr_addr", mem_addr, e_addrw);
                chk("wr_data", mem_wdata, e_wdata);
                if (e_sub) chk("wr_memin", wm_memin, e_old);
            end
            if (cyc == e_done && e_isload) chk("ld_memin", wm_memin, e_old);
            if (busy) begin
                chk("wm_regin", wm_regin, e_regin);
                if (e_mode_chk) chk("wm_mode", wm_mode, {30'h0, e_mode});
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns in the first idle cycle after done.
    task automatic issue(input logic wr, input logic [1:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hammer, input int abort_at);
        logic [1:0]  nm;
        logic [31:0] newv;
        int t0;
        bit err;
        nm   = (mode == 2'b11) ? 2'b00 : mode;
        err  = (nm == 2'b00 && addr[1:0] != 2'b00) || (nm == 2'b01 && addr[0]);
        t0   = cyc;
        newv = wdata;
        req_valid = 1'b1; req_write = wr; req_mode = mode; req_addr = addr; req_wdata = wdata;
        cur_off = addr[1:0];
        last_t0 = t0;
        e_busy = t0 + 1; e_rd = -1; e_wr = -1; e_isload = 0; e_sub = 0; e_err = err;
        e_regin = wdata; e_mode = nm; e_mode_chk = (mode != 2'b11);
        e_addrw = {addr[31:2], 2'b00}; e_old = ref_mem[addr[7:2]];
        if (err) begin
            e_done = t0 + 1;
        end else if (wr && nm == 2'b00) begin
            e_wr = t0 + 1; e_done = t0 + 2; e_wdata = wdata;
        end else if (!wr) begin
            e_rd = t0 + 1; e_done = t0 + 2 + L; e_isload = 1;
            e_load = extract(e_old, nm, addr[1:0]);
        end else begin
            e_rd = t0 + 1; e_wr = t0 + 2 + L; e_done = t0 + 3 + L; e_sub = 1;
            e_wdata = merge_word(e_old, wdata, nm, addr[1:0]);
            newv = e_wdata;
        end
        while (cyc < e_done + 1) begin
            @(posedge clk); #1;
            if (abort_at > 0 && cyc == t0 + abort_at) begin
                reset_n = 1'b0;
                e_busy = -1; e_rd = -1; e_wr = -1; e_done = -1; e_isload = 0; e_err = 0;
                exp_load = 32'h0;
                req_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
                return;
            end
            if (hammer) begin
                req_valid = (cyc <= e_done); req_write = 1'b1; req_mode = 2'b00;
                req_addr = 32'h30; req_wdata = 32'h0BADF00D;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (wr && !err) ref_mem[addr[7:2]] = newv;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00;
        req_addr = 32'h0; req_wdata = 32'h0; preload = 1'b1; cur_off = 2'b00;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[2] = 32'hCAFEBABE; ref_mem[8] = 32'h11223344; ref_mem[9] = 32'h99887766;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        chk("rst_ready", req_ready, 1);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_done", done, 0);
        chk("rst_align_err", align_err, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_wm_memin", wm_memin, 0);
        chk("rst_wm_regin", wm_regin, 0);
        chk("rst_wm_mode", {30'h0, wm_mode}, 0);

        @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        issue(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 0);
        chk("ws_mem", bmem[4], 32'hDEADBEEF);
        chk("ws_latency", last_done - last_t0, 2);

        issue(1'b1, 2'b10, 32'h20, 32'h000000AB, 0, 0);
        chk("bs_mem", bmem[8], 32'h112233AB);
        chk("bs_latency", last_done - last_t0, 6);

        issue(1'b0, 2'b01, 32'h08, 32'h0, 0, 0);
        chk("hl_data", load_data, 32'h0000BABE);
        chk("hl_latency", last_done - last_t0, 5);

        issue(1'b1, 2'b01, 32'h03, 32'h00005555, 0, 0);
        chk("mis_load_data", load_data, 32'h0000BABE);
        chk("mis_latency", last_done - last_t0, 1);

        issue(1'b0, 2'b00, 32'h10, 32'h0, 1, 0);
        chk("busy_ignore_data", load_data, 32'hDEADBEEF);
        chk("busy_ignore_mem", bmem[12], 32'h0);

        issue(1'b0, 2'b10, 32'h22, 32'h0, 0, 0);
        chk("bl_data", load_data, 32'h00000022);

        issue(1'b1, 2'b01, 32'h0A, 32'h00001234, 0, 0);
        chk("hs_mem", bmem[2], 32'h1234BABE);

        issue(1'b1, 2'b11, 32'h14, 32'h55AA55AA, 0, 0);
        chk("m11_latency", last_done - last_t0, 2);

        issue(1'b0, 2'b00, 32'h11, 32'h0, 0, 0);
        issue(1'b1, 2'b10, 32'h23, 32'h000000C7, 0, 0);

        issue(1'b1, 2'b10, 32'h24, 32'h000000EE, 0, 2);
        chk("abort_mem", bmem[9], 32'h99887766);
        chk("abort_ready", req_ready, 1);

        issue(1'b0, 2'b00, 32'h20, 32'h0, 0, 0);
        chk("post_rst_load", load_data, 32'hC72233AB);

        for (int i = 0; i < 16; i++) chk("final_mem", bmem[i], ref_mem[i]);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
